// File: rtl/program_loader.sv
// program_loader: boot-time image loader. Receives a framed byte stream
// (sync, 16-bit word count, little-endian payload, 8-bit additive checksum).
// It writes the assembled 32-bit words into program memory. The core is
// held in reset until a verified image is resident.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_SYNC | idle after reset, dropping bytes until 0xA5
// LEN_LO    | expecting low byte of word count
// LEN_HI    | expecting high byte of word count, bounds-checked here
// DATA      | assembling payload words and issuing memory writes
// CHECK     | expecting checksum byte
// DONE      | image verified, core released; 0xA5 restarts a load
// ERROR     | frame rejected, core held; 0xA5 restarts a load
module program_loader #(
  parameter int PROGRAM_MEMORY_DEPTH = 64,
  parameter int TIMEOUT_CYCLES       = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_data_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        core_reset_o,
  output logic        done_o,
  output logic        error_o,
  output logic [15:0] words_loaded_o
);

  localparam logic [2:0] S_WAIT_SYNC = 3'd0;
  localparam logic [2:0] S_LEN_LO    = 3'd1;
  localparam logic [2:0] S_LEN_HI    = 3'd2;
  localparam logic [2:0] S_DATA      = 3'd3;
  localparam logic [2:0] S_CHECK     = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;
  localparam logic [2:0] S_ERROR     = 3'd6;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         TW        = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]    state;
  logic [7:0]    len_lo;
  logic [15:0]   len;
  logic [15:0]   index;
  logic [1:0]    lane;
  logic [23:0]   partial;
  logic [7:0]    chk;
  logic [TW-1:0] idle_cnt;

  logic          accept;
  logic          timer_active;
  logic          timed_out;
  logic [15:0]   len_in;

  assign accept       = byte_valid_i && byte_ready_o;
  assign timer_active = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                        (state == S_DATA)   || (state == S_CHECK);
  // Down-counter reaches zero after TIMEOUT_CYCLES idle edges; the next
  // idle edge is the one that aborts.
  assign timed_out    = timer_active && !accept && (idle_cnt == '0);
  assign len_in       = {byte_data_i, len_lo};

  // Loader state machine, word assembly, write port and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_WAIT_SYNC;
      len_lo         <= '0;
      len            <= '0;
      index          <= '0;
      lane           <= '0;
      partial        <= '0;
      chk            <= '0;
      idle_cnt       <= TW'(TIMEOUT_CYCLES);
      byte_ready_o   <= 1'b0;
      mem_we_o       <= 1'b0;
      mem_addr_o     <= '0;
      mem_wdata_o    <= '0;
      core_reset_o   <= 1'b1;
      done_o         <= 1'b0;
      error_o        <= 1'b0;
      words_loaded_o <= '0;
    end else begin
      byte_ready_o <= 1'b1;
      mem_we_o     <= 1'b0;

      if (accept)
        idle_cnt <= TW'(TIMEOUT_CYCLES);
      else if (timer_active && idle_cnt != '0)
        idle_cnt <= idle_cnt - TW'(1);

      if (timed_out) begin
        state   <= S_ERROR;
        error_o <= 1'b1;
      end else if (accept) begin
        case (state)
          S_WAIT_SYNC: begin
            if (byte_data_i == SYNC_BYTE) state <= S_LEN_LO;
          end
          S_LEN_LO: begin
            len_lo <= byte_data_i;
            state  <= S_LEN_HI;
          end
          S_LEN_HI: begin
            if (len_in == 16'd0 || len_in > 16'(PROGRAM_MEMORY_DEPTH)) begin
              state   <= S_ERROR;
              error_o <= 1'b1;
            end else begin
              len            <= len_in;
              index          <= '0;
              lane           <= '0;
              chk            <= '0;
              words_loaded_o <= '0;
              state          <= S_DATA;
            end
          end
          S_DATA: begin
            chk <= chk + byte_data_i;
            if (lane == 2'd3) begin
              mem_we_o       <= 1'b1;
              mem_addr_o     <= {14'd0, index, 2'b00};
              mem_wdata_o    <= {byte_data_i, partial};
              index          <= index + 16'd1;
              words_loaded_o <= words_loaded_o + 16'd1;
              lane           <= 2'd0;
              if (index == len - 16'd1) state <= S_CHECK;
            end else begin
              // Shift right so lane 0 ends up in bits [7:0].
              partial <= {byte_data_i, partial[23:8]};
              lane    <= lane + 2'd1;
            end
          end
          S_CHECK: begin
            if (byte_data_i == chk) begin
              state        <= S_DONE;
              done_o       <= 1'b1;
              core_reset_o <= 1'b0;
            end else begin
              state   <= S_ERROR;
              error_o <= 1'b1;
            end
          end
          S_DONE, S_ERROR: begin
            if (byte_data_i == SYNC_BYTE) begin
              state        <= S_LEN_LO;
              core_reset_o <= 1'b1;
              done_o       <= 1'b0;
              error_o      <= 1'b0;
            end
          end
          default: state <= S_WAIT_SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader with a short timeout.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_reset;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_addr [0:511];
  logic [31:0] wr_data [0:511];
  int          wr_cnt = 0;

  logic [7:0] frame [0:299];
  int         frame_len = 0;

  program_loader #(.PROGRAM_MEMORY_DEPTH(64), .TIMEOUT_CYCLES(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .byte_data_i    (byte_data),
    .byte_valid_i   (byte_valid),
    .byte_ready_o   (byte_ready),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .core_reset_o   (core_reset),
    .done_o         (done),
    .error_o        (error),
    .words_loaded_o (words_loaded)
  );

  always #5 clk = ~clk;

  // Record every cycle in which the write strobe is high.
  always @(negedge clk) begin
    if (mem_we === 1'b1 && wr_cnt < 512) begin
      wr_addr[wr_cnt] = mem_addr;
      wr_data[wr_cnt] = mem_wdata;
      wr_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    byte_data  = b;
    byte_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(frame[i]);
    byte_valid = 1'b0;
  endtask

  task automatic build_good(input logic [7:0] chk);
    frame[0] = 8'hA5; frame[1] = 8'h02; frame[2] = 8'h00;
    frame[3] = 8'h13; frame[4] = 8'h05; frame[5] = 8'h50; frame[6] = 8'h00;
    frame[7] = 8'h93; frame[8] = 8'h05; frame[9] = 8'hA5; frame[10] = 8'h00;
    frame[11] = chk;
    frame_len = 12;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (byte_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 ||
        mem_wdata !== 32'h0 || core_reset !== 1'b1 || done !== 1'b0 ||
        error !== 1'b0 || words_loaded !== 16'h0) begin
      errors++;
      $display("FAIL reset_values: ready=%b we=%b addr=%h wdata=%h crst=%b done=%b err=%b wl=%0d expected 0 0 0 0 1 0 0 0",
               byte_ready, mem_we, mem_addr, mem_wdata, core_reset, done, error, words_loaded);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b expected 1", byte_ready);
    end
  endtask

  task automatic test_good_load;
    int base;
    base = wr_cnt;
    build_good(8'hA5);
    for (int i = 0; i < 11; i++) send_byte(frame[i]);
    checks++;
    if (done !== 1'b0 || core_reset !== 1'b1) begin
      errors++;
      $display("FAIL good_before_chk: done=%b crst=%b expected 0 1", done, core_reset);
    end
    send_byte(frame[11]);
    byte_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || core_reset !== 1'b0 || error !== 1'b0 || words_loaded !== 16'd2) begin
      errors++;
      $display("FAIL good_status: done=%b crst=%b err=%b wl=%0d expected 1 0 0 2",
               done, core_reset, error, words_loaded);
    end
    idle(2);
    checks++;
    if (wr_cnt - base != 2 || wr_addr[base] !== 32'h0 || wr_data[base] !== 32'h00500513 ||
        wr_addr[base+1] !== 32'h4 || wr_data[base+1] !== 32'h00A50593) begin
      errors++;
      $display("FAIL good_writes: count=%0d w0=%h:%h w1=%h:%h expected 2 0:00500513 4:00a50593",
               wr_cnt - base, wr_addr[base], wr_data[base], wr_addr[base+1], wr_data[base+1]);
    end
  endtask

  task automatic test_bad_checksum;
    int base;
    base = wr_cnt;
    build_good(8'h00);
    send_frame(0, 11);
    checks++;
    if (error !== 1'b1 || core_reset !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL bad_chk_status: err=%b crst=%b done=%b expected 1 1 0", error, core_reset, done);
    end
    idle(2);
    checks++;
    if (wr_cnt - base != 2 || wr_data[base+1] !== 32'h00A50593) begin
      errors++;
      $display("FAIL bad_chk_writes: count=%0d expected 2", wr_cnt - base);
    end
  endtask

  task automatic test_length_bounds;
    int base;
    logic [7:0] sum;
    base = wr_cnt;
    send_byte(8'hA5);
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL restart_from_error: err=%b expected 0", error);
    end
    send_byte(8'h41);
    send_byte(8'h00);
    byte_valid = 1'b0;
    checks++;
    if (error !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL len_65: err=%b done=%b expected 1 0", error, done);
    end
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    byte_valid = 1'b0;
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL len_0: err=%b expected 1", error);
    end
    idle(2);
    checks++;
    if (wr_cnt != base) begin
      errors++;
      $display("FAIL len_no_write: count=%0d expected 0", wr_cnt - base);
    end
    frame[0] = 8'hA5; frame[1] = 8'h40; frame[2] = 8'h00;
    sum = 8'h00;
    for (int i = 0; i < 256; i++) begin
      frame[3+i] = 8'(i);
      sum = sum + 8'(i);
    end
    frame[259] = sum;
    send_frame(0, 259);
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || words_loaded !== 16'd64) begin
      errors++;
      $display("FAIL len_64_status: done=%b err=%b wl=%0d expected 1 0 64", done, error, words_loaded);
    end
    idle(2);
    checks++;
    if (wr_cnt - base != 64 || wr_addr[wr_cnt-1] !== 32'hFC || wr_data[wr_cnt-1] !== 32'hFFFEFDFC ||
        wr_data[base] !== 32'h03020100) begin
      errors++;
      $display("FAIL len_64_writes: count=%0d last=%h:%h expected 64 fc:fffefdfc",
               wr_cnt - base, wr_addr[wr_cnt-1], wr_data[wr_cnt-1]);
    end
  endtask

  task automatic test_timeout;
    int base;
    base = wr_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    idle(16);
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: err=%b expected 0 at 16 cycles", error);
    end
    idle(1);
    checks++;
    if (error !== 1'b1 || core_reset !== 1'b1 || wr_cnt != base) begin
      errors++;
      $display("FAIL timeout_fire: err=%b crst=%b writes=%0d expected 1 1 0", error, core_reset, wr_cnt - base);
    end
    build_good(8'hA5);
    send_frame(0, 11);
    checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL timeout_recover: done=%b err=%b expected 1 0", done, error);
    end
  endtask

  task automatic test_reset_mid_word;
    int base;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    reset = 1'b1;
    byte_data = 8'h33;
    byte_valid = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    byte_valid = 1'b0;
    checks++;
    if (byte_ready !== 1'b0 || core_reset !== 1'b1 || done !== 1'b0 || words_loaded !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset_values: ready=%b crst=%b done=%b wl=%0d expected 0 1 0 0",
               byte_ready, core_reset, done, words_loaded);
    end
    idle(1);
    base = wr_cnt;
    frame[0] = 8'hA5; frame[1] = 8'h01; frame[2] = 8'h00;
    frame[3] = 8'hAA; frame[4] = 8'hBB; frame[5] = 8'hCC; frame[6] = 8'hDD;
    frame[7] = 8'h0E;
    send_frame(0, 7);
    checks++;
    if (done !== 1'b1 || words_loaded !== 16'd1) begin
      errors++;
      $display("FAIL mid_reset_done: done=%b wl=%0d expected 1 1", done, words_loaded);
    end
    idle(2);
    checks++;
    if (wr_cnt - base != 1 || wr_addr[base] !== 32'h0 || wr_data[base] !== 32'hDDCCBBAA) begin
      errors++;
      $display("FAIL mid_reset_write: count=%0d w=%h:%h expected 1 0:ddccbbaa",
               wr_cnt - base, wr_addr[base], wr_data[base]);
    end
  endtask

  task automatic test_restart_from_done;
    send_byte(8'hA5);
    byte_valid = 1'b0;
    checks++;
    if (core_reset !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL restart_status: crst=%b done=%b expected 1 0", core_reset, done);
    end
    idle(3);
    build_good(8'hA5);
    send_frame(1, 11);
    checks++;
    if (done !== 1'b1 || core_reset !== 1'b0 || words_loaded !== 16'd2) begin
      errors++;
      $display("FAIL restart_reload: done=%b crst=%b wl=%0d expected 1 0 2", done, core_reset, words_loaded);
    end
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_length_bounds();
    test_timeout();
    test_reset_mid_word();
    test_restart_from_done();
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
